// File: rtl/led_fade_pwm.sv
// ---------------------------------------------------------------------------
// led_fade_pwm
//
// Output stage for the Knight Rider scanner. Each of the 8 LEDs has its own
// brightness register. The register loads full scale while its pattern bit
// is set, and it decays by DECAY_STEP on every decay strobe. A shared PWM
// counter turns each brightness into a duty cycle, so a recently lit LED
// leaves a glowing tail behind the moving dot.
//
// Timebase (all counters free-run):
//   div_cnt : 0..PWM_DIV-1       -> pwm_tick  on the last count
//   pwm_cnt : 0..MAX-1           -> frame_end on pwm_tick at the last count
//   frm_cnt : 0..DECAY_FRAMES-1  -> decay_stb on frame_end at the last count
//
// Ports:
//   CLK12M     in   1  system clock, rising edge
//   reset      in   1  synchronous, active-high
//   pattern_in in   8  LED pattern from the scanner, sampled every cycle
//   fade_en    in   1  1 = PWM with fading tail, 0 = direct pass-through
//   LEDS       out  8  registered LED drive
// ---------------------------------------------------------------------------
module led_fade_pwm #(
    parameter int unsigned PWM_BITS     = 4,    // brightness width, 2..8
    parameter int unsigned PWM_DIV      = 64,   // clocks per PWM step, >= 1
    parameter int unsigned DECAY_FRAMES = 256,  // frames per decay strobe, >= 1
    parameter int unsigned DECAY_STEP   = 2     // decrement per strobe, 1..MAX
) (
    input  logic       CLK12M,
    input  logic       reset,
    input  logic [7:0] pattern_in,
    input  logic       fade_en,
    output logic [7:0] LEDS
);

    localparam int unsigned MAX   = (1 << PWM_BITS) - 1;
    // Counters whose range is a single value still get one bit so the
    // declarations stay legal; they simply sit at zero.
    localparam int unsigned DIV_W = (PWM_DIV > 1)      ? $clog2(PWM_DIV)      : 1;
    localparam int unsigned FRM_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(PWM_DIV - 1);
    localparam logic [FRM_W-1:0]    FRM_LAST = FRM_W'(DECAY_FRAMES - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(MAX - 1);
    localparam logic [PWM_BITS-1:0] BRI_MAX  = PWM_BITS'(MAX);
    localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(DECAY_STEP);

    logic [DIV_W-1:0]          div_cnt;
    logic [PWM_BITS-1:0]       pwm_cnt;
    logic [FRM_W-1:0]          frm_cnt;
    logic [7:0][PWM_BITS-1:0]  bri;
    logic [7:0][PWM_BITS-1:0]  bri_next;
    logic [7:0]                led_next;

    logic pwm_tick;
    logic frame_end;
    logic decay_stb;

    // -----------------------------------------------------------------------
    // Timebase strobes
    // -----------------------------------------------------------------------
    always_comb begin
        pwm_tick  = (div_cnt == DIV_LAST);
        frame_end = pwm_tick && (pwm_cnt == CNT_LAST);
        decay_stb = frame_end && (frm_cnt == FRM_LAST);
    end

    // Prescaler
    always_ff @(posedge CLK12M) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (pwm_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // PWM compare counter: MAX steps per frame, so bri = MAX is never below
    // the counter and the LED is on for the whole frame.
    always_ff @(posedge CLK12M) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else if (frame_end) begin
            pwm_cnt <= '0;
        end else if (pwm_tick) begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Frame counter
    always_ff @(posedge CLK12M) begin
        if (reset) begin
            frm_cnt <= '0;
        end else if (decay_stb) begin
            frm_cnt <= '0;
        end else if (frame_end) begin
            frm_cnt <= frm_cnt + FRM_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Per-LED brightness: load beats decay; decay saturates at zero.
    // Brightness tracks pattern_in regardless of fade_en.
    // -----------------------------------------------------------------------
    always_comb begin
        bri_next = bri;
        for (int unsigned i = 0; i < 8; i++) begin
            if (pattern_in[i]) begin
                bri_next[i] = BRI_MAX;
            end else if (decay_stb) begin
                bri_next[i] = (bri[i] > STEP) ? (bri[i] - STEP) : '0;
            end
        end
    end

    always_ff @(posedge CLK12M) begin
        if (reset) begin
            bri <= '0;
        end else begin
            bri <= bri_next;
        end
    end

    // -----------------------------------------------------------------------
    // Output compare. The current brightness is used directly, so a change
    // mid-frame shows up at the very next compare.
    // -----------------------------------------------------------------------
    always_comb begin
        led_next = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (fade_en) begin
                led_next[i] = (pwm_cnt < bri[i]);
            end else begin
                led_next[i] = pattern_in[i];
            end
        end
    end

    always_ff @(posedge CLK12M) begin
        if (reset) begin
            LEDS <= '0;
        end else begin
            LEDS <= led_next;
        end
    end

endmodule
